// File: rtl/num_edit_ctrl.sv
// rtl/num_edit_ctrl.sv - four-nibble edit controller: button sync/debounce, round-robin arbiter, shared +/-1 unit
// Optional debounce counters are enabled by defining NUMEDIT_DEBOUNCE_EN.
module num_edit_ctrl #(
  parameter int          DB_COUNT   = 50000,
  parameter logic [15:0] INIT_VALUE = 16'hABCD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic [3:0]  sw,
  output logic [15:0] num,
  output logic        busy,
  output logic [3:0]  grant
);

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  state_t      state, state_nxt;
  logic [3:0]  sync1, sync2;
  logic [3:0]  level, level_q;
  logic [3:0]  rise;
  logic [3:0]  pending;
  logic [1:0]  ptr;
  logic [1:0]  sel;
  logic        dir;
  logic [3:0]  res;
  logic [1:0]  pick;
  logic [1:0]  scan_idx;
  logic        found;
  logic [3:0]  cur_nib;
  logic [3:0]  result;
  logic [3:0]  wb_clr;

  // two-flop synchronizer and edge-detect history for the raw buttons
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= '0;
      sync2   <= '0;
      level_q <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
    end
  end

`ifdef NUMEDIT_DEBOUNCE_EN
  localparam int CW = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] db_cnt;

    // level follows the synchronized input only after DB_COUNT disagreeing samples in a row
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        db_cnt   <= '0;
        level[i] <= 1'b0;
      end else if (sync2[i] != level[i]) begin
        if (db_cnt == CW'(DB_COUNT - 1)) begin
          db_cnt   <= '0;
          level[i] <= sync2[i];
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end
`else
  // inputs are trusted to be clean: the synchronizer output is the debounced level
  assign level = sync2;
`endif

  assign rise = level & ~level_q;

  // round-robin pick: first pending channel at or after ptr
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + k[1:0];
      if (!found && pending[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
  end

  // shared 4-bit +/-1 unit; wraps within the nibble, never touches neighbours
  always_comb begin
    cur_nib = num[{sel, 2'b00} +: 4];
    result  = dir ? (cur_nib - 4'd1) : (cur_nib + 4'd1);
  end

  // FSM next state and channel-facing outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    grant     = '0;
    wb_clr    = '0;
    case (state)
      IDLE: begin
        if (|pending) state_nxt = CALC;
      end
      CALC: begin
        grant     = 4'b0001 << sel;
        state_nxt = WB;
      end
      WB: begin
        grant     = 4'b0001 << sel;
        wb_clr    = 4'b0001 << sel;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // datapath: pending requests, operand latch, result register and write-back
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num     <= INIT_VALUE;
      pending <= '0;
      ptr     <= '0;
      sel     <= '0;
      dir     <= 1'b0;
      res     <= '0;
    end else begin
      // a new edge in the same cycle as the write-back clear keeps the request alive
      pending <= (pending & ~wb_clr) | rise;
      case (state)
        IDLE: begin
          if (|pending) begin
            sel <= pick;
            dir <= sw[pick];
          end
        end
        CALC: res <= result;
        WB: begin
          num[{sel, 2'b00} +: 4] <= res;
          ptr                    <= sel + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_num_edit_ctrl.sv
// tb/tb_num_edit_ctrl.sv - directed self-checking bench for num_edit_ctrl
module tb_num_edit_ctrl;

`ifdef NUMEDIT_DEBOUNCE_EN
  localparam int DBL = 4;
`else
  localparam int DBL = 0;
`endif
  localparam int PL = 3 + DBL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn = '0;
  logic [3:0]  sw = '0;
  logic [15:0] num;
  logic        busy;
  logic [3:0]  grant;

  int errors = 0;
  int checks = 0;

  num_edit_ctrl #(.DB_COUNT(4), .INIT_VALUE(16'hABCD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .sw    (sw),
    .num   (num),
    .busy  (busy),
    .grant (grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn   = '0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] b, input int len);
    btn = b;
    tick(len);
    btn = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    check("reset_num", 32'(num), 32'h0000ABCD);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_grant", 32'(grant), 32'h0);

    // single increment latency on channel 0
    sw = 4'b0000;
    press(4'b0001, PL);
    tick(1);
    check("lat_busy", 32'(busy), 32'h1);
    check("lat_grant", 32'(grant), 32'h1);
    tick(1);
    check("lat_before", 32'(num), 32'h0000ABCD);
    tick(1);
    check("lat_write", 32'(num), 32'h0000ABCE);
    check("lat_busy_fall", 32'(busy), 32'h0);
    tick(12);
    check("lat_once", 32'(num), 32'h0000ABCE);

    // wrap within nibble 0, then decrement nibble 3
    do_reset();
    sw = 4'b0000;
    press(4'b0001, PL); tick(12);
    check("wrap1", 32'(num), 32'h0000ABCE);
    press(4'b0001, PL); tick(12);
    check("wrap2", 32'(num), 32'h0000ABCF);
    press(4'b0001, PL); tick(12);
    check("wrap3", 32'(num), 32'h0000ABC0);
    check("wrap_hi", 32'(num[15:4]), 32'h00000ABC);
    sw = 4'b1000;
    press(4'b1000, PL); tick(12);
    check("dec3", 32'(num), 32'h00009BC0);

    // sw change after the operation is latched must not matter
    do_reset();
    sw = 4'b0000;
    btn = 4'b0001;
    tick(PL);
    btn = '0;
    tick(1);
    sw = 4'b0001;
    tick(10);
    check("sw_latched", 32'(num), 32'h0000ABCE);

    // all four requests at once
    do_reset();
    sw = 4'b0000;
    press(4'b1111, PL);
    tick(1);
    check("arb_g0", 32'(grant), 32'h1);
    tick(2);
    check("arb_gap", 32'(grant), 32'h0);
    check("arb_n0", 32'(num), 32'h0000ABCE);
    tick(1);
    check("arb_g1", 32'(grant), 32'h2);
    tick(3);
    check("arb_g2", 32'(grant), 32'h4);
    tick(3);
    check("arb_g3", 32'(grant), 32'h8);
    tick(2);
    check("arb_final", 32'(num), 32'h0000BCDE);
    tick(1);
    check("arb_idle", 32'(busy), 32'h0);

    // reset while channel 2 is in CALC
    do_reset();
    sw = 4'b0000;
    press(4'b0100, PL);
    tick(1);
    check("mid_grant", 32'(grant), 32'h4);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    check("mid_num", 32'(num), 32'h0000ABCD);
    check("mid_pending", 32'(dut.pending), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);

`ifdef NUMEDIT_DEBOUNCE_EN
    // short glitch is filtered, long press gives one increment of nibble 1
    do_reset();
    sw = 4'b0000;
    press(4'b0010, 3); tick(15);
    check("db_short", 32'(num), 32'h0000ABCD);
    press(4'b0010, 10); tick(15);
    check("db_long", 32'(num), 32'h0000ABDD);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
